// File: rtl/jt51_slot_wr_if.sv
// Write-side bus of the jt51 slot-write front end.
// The CPU-side master issues single-slot writes; the slave reports
// backpressure and one-clk completion/error pulses.
interface jt51_slot_wr_if #(
  parameter int width  = 5,
  parameter int slot_w = 5
);
  logic              wr_req;
  logic [slot_w-1:0] wr_slot;
  logic [width-1:0]  wr_data;
  logic              wr_busy;
  logic              wr_done;
  logic              wr_err;

  modport master (
    output wr_req, wr_slot, wr_data,
    input  wr_busy, wr_done, wr_err
  );

  modport slave (
    input  wr_req, wr_slot, wr_data,
    output wr_busy, wr_done, wr_err
  );
endinterface

// File: rtl/jt51_slot_wr.sv
// Slot-write front end for a jt51_sh per-slot delay ring.
// Owns the slot counter and a 2-deep in-order write queue. The ring
// normally recirculates (ring_din = ring_drop); when the head entry's
// slot comes round on a cen, its data is injected for that one slot.
module jt51_slot_wr #(
  parameter int   width  = 5,
  parameter int   stages = 32,
  parameter int   slot_w = 5,
  parameter logic rstval = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jt51_slot_wr_if.slave     wr,
  input  logic [width-1:0]  ring_drop,
  output logic [width-1:0]  ring_din,
  output logic [slot_w-1:0] cur_slot,
  output logic              zero
);

  localparam logic [slot_w-1:0] last_slot  = slot_w'(stages - 1);
  localparam logic [slot_w:0]   stages_ext = (slot_w + 1)'(stages);

  // Queue storage: entry 0 is always the head.
  logic [slot_w-1:0] slot_reg [2];
  logic [width-1:0]  data_reg [2];
  logic [1:0]        count_reg;
  logic [slot_w-1:0] cur_reg;
  logic              done_reg;
  logic              err_reg;

  logic       accept;
  logic       in_range;
  logic       push;
  logic       pop;
  logic [1:0] wr_idx;
  logic [1:0] count_next;

  // Request acceptance and commit decision. The commit only looks at
  // registered queue state, so wr_* never reaches ring_din combinationally.
  always_comb begin
    accept     = wr.wr_req & ~wr.wr_busy;
    in_range   = ({1'b0, wr.wr_slot} < stages_ext);
    push       = accept & in_range;
    pop        = cen & (count_reg != 2'd0) & (slot_reg[0] == cur_reg);
    wr_idx     = count_reg - {1'b0, pop};
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // Slot counter: advances once per cen, wrapping at stages-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_reg <= '0;
    end else if (cen) begin
      cur_reg <= (cur_reg == last_slot) ? '0 : cur_reg + 1'b1;
    end
  end

  // Queue update: pop shifts entry 1 down, push lands behind the survivors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= 2'd0;
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      data_reg[0] <= '0;
      data_reg[1] <= '0;
    end else begin
      count_reg <= count_next;
      if (pop) begin
        slot_reg[0] <= slot_reg[1];
        data_reg[0] <= data_reg[1];
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          slot_reg[0] <= wr.wr_slot;
          data_reg[0] <= wr.wr_data;
        end else begin
          slot_reg[1] <= wr.wr_slot;
          data_reg[1] <= wr.wr_data;
        end
      end
    end
  end

  // Status pulses, one clk after the commit or the rejected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= pop;
      err_reg  <= accept & ~in_range;
    end
  end

  // Ring input: reset value, injected head data, or recirculation.
  always_comb begin
    ring_din = ring_drop;
    if (rst) begin
      ring_din = {width{rstval}};
    end else if (pop) begin
      ring_din = data_reg[0];
    end
  end

  assign wr.wr_busy = (count_reg == 2'd2);
  assign wr.wr_done = done_reg;
  assign wr.wr_err  = err_reg;
  assign cur_slot   = cur_reg;
  assign zero       = (cur_reg == '0);

endmodule

// File: tb/tb_jt51_slot_wr.sv
// Self-checking bench for jt51_slot_wr: a queue-based reference model for
// the 32-slot instance, a latency vector table, directed corner sequences,
// and a 24-slot instance for out-of-range and reset-discard behaviour.
module tb_jt51_slot_wr;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic [4:0] ring_drop, a_din, a_cur;
  logic       a_zero;
  logic       rst_b, cen_b;
  logic [4:0] ring_drop_b, b_din, b_cur;
  logic       b_zero;

  jt51_slot_wr_if #(.width(5), .slot_w(5)) a_if ();
  jt51_slot_wr_if #(.width(5), .slot_w(5)) b_if ();

  jt51_slot_wr #(.width(5), .stages(32), .slot_w(5), .rstval(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cen(cen), .wr(a_if.slave),
    .ring_drop(ring_drop), .ring_din(a_din), .cur_slot(a_cur), .zero(a_zero)
  );

  jt51_slot_wr #(.width(5), .stages(24), .slot_w(5), .rstval(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .cen(cen_b), .wr(b_if.slave),
    .ring_drop(ring_drop_b), .ring_din(b_din), .cur_slot(b_cur), .zero(b_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [4:0] data;
  } ent_t;

  typedef struct {
    int         a;
    int         s;
    logic [4:0] d;
    int         lat;
  } lat_vec_t;

  ent_t       mq[$];
  int         mcur;
  logic       mdone, merr;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [4:0] seen_din, seen_cur;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mcur  = 0;
    mdone = 1'b0;
    merr  = 1'b0;
  endtask

  // One clk of DUT A: check outputs at negedge against the model, then
  // advance the model on the posedge. Returns at posedge+1.
  task automatic cycle();
    bit         hit, acc;
    logic [4:0] exp_din;
    @(negedge clk);
    hit = !rst && cen && mq.size() > 0 && mq[0].slot == mcur;
    exp_din = rst ? 5'd0 : (hit ? mq[0].data : ring_drop);
    chk("ring_din", a_din, exp_din);
    chk("cur_slot", a_cur, mcur);
    chk("zero", a_zero, mcur == 0);
    chk("wr_busy", a_if.wr_busy, mq.size() == 2);
    chk("wr_done", a_if.wr_done, mdone);
    chk("wr_err", a_if.wr_err, merr);
    seen_din = a_din;
    seen_cur = a_cur;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      acc   = a_if.wr_req && mq.size() < 2;
      mdone = hit;
      merr  = acc && (a_if.wr_slot >= 32);
      if (hit) void'(mq.pop_front());
      if (acc && a_if.wr_slot < 32) mq.push_back('{slot: int'(a_if.wr_slot), data: a_if.wr_data});
      if (cen) mcur = (mcur + 1) % 32;
    end
    #1;
  endtask

  task automatic write_a(input int slot, input logic [4:0] data);
    a_if.wr_req  = 1'b1;
    a_if.wr_slot = 5'(slot);
    a_if.wr_data = data;
    cycle();
    a_if.wr_req  = 1'b0;
  endtask

  task automatic drain_and_goto(input int target);
    for (int k = 0; k < 80 && mq.size() != 0; k++) cycle();
    for (int k = 0; k < 64 && mcur != target; k++) cycle();
    chk("goto_slot", a_cur, target);
  endtask

  lat_vec_t tbl[6];
  int       lat, zcount, mism, dones, bslot;
  bit       committed;
  int       cslot[$];
  logic [4:0] cdat[$];

  initial begin
    tbl[0] = '{a: 3,  s: 7,  d: 5'h15, lat: 4};
    tbl[1] = '{a: 3,  s: 3,  d: 5'h0A, lat: 32};
    tbl[2] = '{a: 3,  s: 2,  d: 5'h11, lat: 31};
    tbl[3] = '{a: 31, s: 0,  d: 5'h1E, lat: 1};
    tbl[4] = '{a: 0,  s: 31, d: 5'h07, lat: 31};
    tbl[5] = '{a: 10, s: 11, d: 5'h19, lat: 1};

    rst = 1'b1; cen = 1'b0; ring_drop = 5'h1F;
    a_if.wr_req = 1'b0; a_if.wr_slot = '0; a_if.wr_data = '0;
    rst_b = 1'b1; cen_b = 1'b1; ring_drop_b = 5'h00;
    b_if.wr_req = 1'b0; b_if.wr_slot = '0; b_if.wr_data = '0;
    model_clear();
    cycle(); cycle();
    rst = 1'b0; rst_b = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cen          = ($urandom_range(0, 3) != 0);
      ring_drop    = 5'($urandom);
      a_if.wr_req  = ($urandom_range(0, 2) == 0);
      a_if.wr_slot = 5'($urandom_range(0, 31));
      a_if.wr_data = 5'($urandom);
      cycle();
    end
    a_if.wr_req = 1'b0;

    // Asynchronous reset mid-operation with drop held at 1F.
    cen = 1'b1; ring_drop = 5'h1F;
    write_a(int'(a_cur ^ 5'd16), 5'h0B);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_din", a_din, 0);
    chk("rst_async_cur", a_cur, 0);
    chk("rst_async_busy", a_if.wr_busy, 0);
    chk("rst_async_zero", a_zero, 1);
    model_clear();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_release_din", seen_din, 5'h1F);

    // Free-running wrap: zero high for exactly one of 32 cen periods.
    zcount = 0;
    for (int i = 0; i < 32; i++) begin
      ring_drop = 5'($urandom);
      cycle();
      if (a_zero) zcount++;
    end
    chk("zero_once_per_pass", zcount, 1);

    // Latency table.
    for (int v = 0; v < 6; v++) begin
      cen = 1'b1;
      drain_and_goto(tbl[v].a);
      ring_drop = tbl[v].d ^ 5'h1F;
      write_a(tbl[v].s, tbl[v].d);
      lat = 0; committed = 0;
      for (int k = 0; k < 40 && !committed; k++) begin
        cycle();
        lat++;
        if (seen_din == tbl[v].d && seen_cur == 5'(tbl[v].s)) committed = 1;
      end
      chk("commit_latency", lat, tbl[v].lat);
      cycle();
      chk("done_after_commit", a_if.wr_done, 0);
    end

    // Full queue: third write ignored, commits in order at 2 then 9.
    cen = 1'b1; ring_drop = 5'h1F;
    drain_and_goto(20);
    write_a(2, 5'h01);
    write_a(9, 5'h02);
    chk("busy_when_full", a_if.wr_busy, 1);
    write_a(4, 5'h03);
    cslot.delete(); cdat.delete();
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (seen_din != 5'h1F) begin
        cslot.push_back(int'(seen_cur));
        cdat.push_back(seen_din);
      end
    end
    chk("full_commit_count", cslot.size(), 2);
    if (cslot.size() >= 2) begin
      chk("full_first_slot", cslot[0], 2);
      chk("full_first_data", cdat[0], 5'h01);
      chk("full_second_slot", cslot[1], 9);
      chk("full_second_data", cdat[1], 5'h02);
    end

    // cen gating at the head's slot.
    drain_and_goto(5);
    write_a(10, 5'h0C);
    for (int k = 0; k < 40 && mcur != 10; k++) cycle();
    cen = 1'b0; ring_drop = 5'h13;
    for (int i = 0; i < 5; i++) cycle();
    chk("gated_cur", a_cur, 10);
    chk("gated_din", seen_din, 5'h13);
    cen = 1'b1;
    cycle();
    chk("ungated_commit", seen_din, 5'h0C);
    cycle();

    // 24-slot instance: out-of-range write.
    b_if.wr_req = 1'b1; b_if.wr_slot = 5'd30; b_if.wr_data = 5'h05;
    cycle();
    b_if.wr_req = 1'b0;
    chk("b_err_pulse", b_if.wr_err, 1);
    chk("b_err_not_stored", b_if.wr_busy, 0);
    cycle();
    chk("b_err_one_clk", b_if.wr_err, 0);
    mism = 0; dones = 0;
    for (int i = 0; i < 30; i++) begin
      ring_drop_b = 5'($urandom);
      #1;
      if (b_din != ring_drop_b) mism++;
      cycle();
      if (b_if.wr_done) dones++;
    end
    chk("b_err_no_commit", mism, 0);
    chk("b_err_no_done", dones, 0);

    // 24-slot instance: reset discards a pending entry.
    bslot = (int'(b_cur) + 12) % 24;
    b_if.wr_req = 1'b1; b_if.wr_slot = 5'(bslot); b_if.wr_data = 5'h09;
    cycle();
    b_if.wr_req = 1'b0;
    cycle();
    rst_b = 1'b1;
    #1;
    chk("b_rst_cur", b_cur, 0);
    chk("b_rst_din", b_din, 0);
    chk("b_rst_busy", b_if.wr_busy, 0);
    cycle(); cycle();
    rst_b = 1'b0;
    mism = 0; dones = 0;
    for (int i = 0; i < 60; i++) begin
      ring_drop_b = 5'($urandom);
      #1;
      if (b_din != ring_drop_b) mism++;
      cycle();
      if (b_if.wr_done) dones++;
    end
    chk("b_discard_no_inject", mism, 0);
    chk("b_discard_no_done", dones, 0);
    bslot = (int'(b_cur) + 12) % 24;
    b_if.wr_req = 1'b1; b_if.wr_slot = 5'(bslot); b_if.wr_data = 5'h02;
    cycle();
    chk("b_one_entry_not_busy", b_if.wr_busy, 0);
    cycle();
    b_if.wr_req = 1'b0;
    chk("b_two_entries_busy", b_if.wr_busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
